// File: rtl/tlb_write_pack_pkg.sv
// Shared definitions for the TLB write path: packed-entry field positions,
// CP0 register field positions and the write-sequencer state encoding.
package tlb_write_pack_pkg;

    localparam int ENTRY_W = 90;

    // Packed TLB entry fields
    localparam int TLB_VPN2_HI = 89;
    localparam int TLB_VPN2_LO = 71;
    localparam int TLB_ASID_HI = 70;
    localparam int TLB_ASID_LO = 63;
    localparam int TLB_MASK_HI = 62;
    localparam int TLB_MASK_LO = 51;
    localparam int TLB_G_BIT   = 50;
    localparam int TLB_PFN0_HI = 49;
    localparam int TLB_PFN0_LO = 30;
    localparam int TLB_C0_HI   = 29;
    localparam int TLB_C0_LO   = 27;
    localparam int TLB_D0_BIT  = 26;
    localparam int TLB_V0_BIT  = 25;
    localparam int TLB_PFN1_HI = 24;
    localparam int TLB_PFN1_LO = 5;
    localparam int TLB_C1_HI   = 4;
    localparam int TLB_C1_LO   = 2;
    localparam int TLB_D1_BIT  = 1;
    localparam int TLB_V1_BIT  = 0;

    // CP0 register fields
    localparam int CP0_EHI_VPN2_HI = 31;
    localparam int CP0_EHI_VPN2_LO = 13;
    localparam int CP0_EHI_ASID_HI = 7;
    localparam int CP0_EHI_ASID_LO = 0;
    localparam int CP0_PM_MASK_HI  = 24;
    localparam int CP0_PM_MASK_LO  = 13;
    localparam int CP0_LO_PFN_HI   = 25;
    localparam int CP0_LO_PFN_LO   = 6;
    localparam int CP0_LO_C_HI     = 5;
    localparam int CP0_LO_C_LO     = 3;
    localparam int CP0_LO_D_BIT    = 2;
    localparam int CP0_LO_V_BIT    = 1;
    localparam int CP0_LO_G_BIT    = 0;

    typedef logic [ENTRY_W-1:0] tlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wstate_e;

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random register: free-running down-counter that wraps above Wired,
// reloads on a Wired write and holds while a TLB write is in flight.
module tlb_random_reg
    import tlb_write_pack_pkg::*;
#(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze_i,
    input  logic             wired_we_i,
    input  logic [31:0]      wired_i,
    output logic [IDX_W-1:0] random_o
);

    localparam logic [IDX_W-1:0] RANDOM_TOP = IDX_W'(TLB_NUM - 1);

    logic [IDX_W-1:0] random_q;
    logic [IDX_W-1:0] random_d;
    logic             wrap;

    // An out-of-range Wired pins Random at the top entry.
    assign wrap = (wired_i >= 32'(TLB_NUM)) || (random_q <= wired_i[IDX_W-1:0]);

    always_comb begin
        random_d = random_q;
        if (wired_we_i) begin
            random_d = RANDOM_TOP;
        end else if (!freeze_i) begin
            random_d = wrap ? RANDOM_TOP : random_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            random_q <= RANDOM_TOP;
        end else begin
            random_q <= random_d;
        end
    end

    assign random_o = random_q;

endmodule

// File: rtl/tlb_write_pack.sv
// TLBWI/TLBWR write sequencer: packs CP0 state into a TLB entry, then issues
// one registered array write while stalling the pipeline.
module tlb_write_pack
    import tlb_write_pack_pkg::*;
#(
    parameter int TLB_NUM = 16,
    parameter int IDX_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tlbwi_req,
    input  logic               tlbwr_req,
    input  logic [31:0]        cp0_entryhi,
    input  logic [31:0]        cp0_entrylo0,
    input  logic [31:0]        cp0_entrylo1,
    input  logic [31:0]        cp0_pagemask,
    input  logic [31:0]        cp0_index,
    input  logic [31:0]        cp0_wired,
    input  logic               wired_we,
    output logic               tlb_we,
    output logic [IDX_W-1:0]   tlb_widx,
    output logic [ENTRY_W-1:0] tlb_wdata,
    output logic [IDX_W-1:0]   random_out,
    output logic               stall,
    output logic               write_done
);

    wstate_e          state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    tlb_entry_t       data_q, data_d;
    tlb_entry_t       entry_packed;
    logic             req;
    logic             freeze;
    logic [IDX_W-1:0] random_q;
    logic             unused_cp0;

    assign req = tlbwi_req | tlbwr_req;

    always_comb begin
        entry_packed = '0;
        entry_packed[TLB_VPN2_HI:TLB_VPN2_LO] = cp0_entryhi[CP0_EHI_VPN2_HI:CP0_EHI_VPN2_LO];
        entry_packed[TLB_ASID_HI:TLB_ASID_LO] = cp0_entryhi[CP0_EHI_ASID_HI:CP0_EHI_ASID_LO];
        entry_packed[TLB_MASK_HI:TLB_MASK_LO] = cp0_pagemask[CP0_PM_MASK_HI:CP0_PM_MASK_LO];
        // The entry is global only if both halves agree it is.
        entry_packed[TLB_G_BIT] = cp0_entrylo0[CP0_LO_G_BIT] & cp0_entrylo1[CP0_LO_G_BIT];
        entry_packed[TLB_PFN0_HI:TLB_PFN0_LO] = cp0_entrylo0[CP0_LO_PFN_HI:CP0_LO_PFN_LO];
        entry_packed[TLB_C0_HI:TLB_C0_LO]     = cp0_entrylo0[CP0_LO_C_HI:CP0_LO_C_LO];
        entry_packed[TLB_D0_BIT]              = cp0_entrylo0[CP0_LO_D_BIT];
        entry_packed[TLB_V0_BIT]              = cp0_entrylo0[CP0_LO_V_BIT];
        entry_packed[TLB_PFN1_HI:TLB_PFN1_LO] = cp0_entrylo1[CP0_LO_PFN_HI:CP0_LO_PFN_LO];
        entry_packed[TLB_C1_HI:TLB_C1_LO]     = cp0_entrylo1[CP0_LO_C_HI:CP0_LO_C_LO];
        entry_packed[TLB_D1_BIT]              = cp0_entrylo1[CP0_LO_D_BIT];
        entry_packed[TLB_V1_BIT]              = cp0_entrylo1[CP0_LO_V_BIT];
    end

    assign unused_cp0 = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                          cp0_pagemask[31:25], cp0_pagemask[12:0], cp0_index[31:IDX_W]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WRITE;
                    idx_d   = tlbwi_req ? cp0_index[IDX_W-1:0] : random_q;
                    data_d  = entry_packed;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            // Requests still visible here belong to the retiring instruction.
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Random must hold from the accepting cycle so TLBWR sees a stable index.
    assign freeze = (state_q != ST_IDLE) || req;

    tlb_random_reg #(
        .TLB_NUM (TLB_NUM),
        .IDX_W   (IDX_W)
    ) u_random (
        .clk        (clk),
        .rst        (rst),
        .freeze_i   (freeze),
        .wired_we_i (wired_we),
        .wired_i    (cp0_wired),
        .random_o   (random_q)
    );

    assign tlb_we     = (state_q == ST_WRITE);
    assign tlb_widx   = idx_q;
    assign tlb_wdata  = data_q;
    assign random_out = random_q;
    assign stall      = ((state_q == ST_IDLE) && req) || (state_q == ST_WRITE);
    assign write_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tlb_write_pack.sv
// Directed bench for tlb_write_pack: table of packing vectors plus
// hand-written Random, TLBWR, back-to-back and reset-mid-write sequences.
module tb_tlb_write_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tlbwi_req = 1'b0;
    logic        tlbwr_req = 1'b0;
    logic [31:0] cp0_entryhi = '0;
    logic [31:0] cp0_entrylo0 = '0;
    logic [31:0] cp0_entrylo1 = '0;
    logic [31:0] cp0_pagemask = '0;
    logic [31:0] cp0_index = '0;
    logic [31:0] cp0_wired = 32'd3;
    logic        wired_we = 1'b0;
    logic        tlb_we;
    logic [3:0]  tlb_widx;
    logic [89:0] tlb_wdata;
    logic [3:0]  random_out;
    logic        stall;
    logic        write_done;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tlb_write_pack #(.TLB_NUM(16), .IDX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .tlbwi_req    (tlbwi_req),
        .tlbwr_req    (tlbwr_req),
        .cp0_entryhi  (cp0_entryhi),
        .cp0_entrylo0 (cp0_entrylo0),
        .cp0_entrylo1 (cp0_entrylo1),
        .cp0_pagemask (cp0_pagemask),
        .cp0_index    (cp0_index),
        .cp0_wired    (cp0_wired),
        .wired_we     (wired_we),
        .tlb_we       (tlb_we),
        .tlb_widx     (tlb_widx),
        .tlb_wdata    (tlb_wdata),
        .random_out   (random_out),
        .stall        (stall),
        .write_done   (write_done)
    );

    typedef struct {
        string       name;
        logic [31:0] hi, lo0, lo1, pm, idx;
        logic        wi, wr;
        logic [3:0]  exp_widx;
        logic [89:0] exp_wdata;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fields: VPN2,ASID,Mask,G,PFN0,C0,D0,V0,PFN1,C1,D1,V1
        vecs[0] = '{"pack_wi", 32'h1234_50A7, 32'h0123_4567, 32'h0000_0003, 32'h0000_6000,
                    32'd5, 1'b1, 1'b0, 4'd5,
                    {19'h091A2, 8'hA7, 12'h003, 1'b1, 20'h48D15, 3'd4, 1'b1, 1'b1,
                     20'h00000, 3'd0, 1'b0, 1'b1}};
        vecs[1] = '{"gmask_pbit", 32'h8000_2001, 32'h0000_0001, 32'h03FF_FFFE, 32'h01FF_E000,
                    32'h8000_000A, 1'b1, 1'b0, 4'd10,
                    {19'h40001, 8'h01, 12'hFFF, 1'b0, 20'h00000, 3'd0, 1'b0, 1'b0,
                     20'hFFFFF, 3'd7, 1'b1, 1'b1}};
        vecs[2] = '{"both_req", 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                    32'd3, 1'b1, 1'b1, 4'd3,
                    {19'h0, 8'h0, 12'h0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0,
                     20'h0, 3'd0, 1'b0, 1'b0}};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_we", tlb_we, 0);
        chk("rst_widx", tlb_widx, 0);
        chk("rst_wdata", tlb_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", write_done, 0);

        // Random 15..3 then wraps to 15 (Wired=3)
        for (int k = 0; k < 14; k++) begin
            chk($sformatf("rand_seq%0d", k), random_out, (k < 13) ? 15 - k : 15);
            tick();
        end
        tick();
        tick();
        #1;
        chk("rand_pre_wwe", random_out, 12);
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        #1;
        chk("rand_wwe", random_out, 15);
        tick();
        #1;
        chk("rand_after_wwe", random_out, 14);

        // Wired beyond TLB_NUM pins Random at 15
        cp0_wired = 32'd20;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk($sformatf("rand_wired20_%0d", k), random_out, 15);
        end
        cp0_wired = 32'd3;

        // TLBWR at Random=9
        for (int k = 0; k < 6; k++) tick();
        #1;
        chk("wr_rand_pre", random_out, 9);
        cp0_entryhi = 32'h0000_2000;
        tlbwr_req = 1'b1;
        #1;
        chk("wr_stall_T", stall, 1);
        tick();
        #1;
        chk("wr_we", tlb_we, 1);
        chk("wr_widx", tlb_widx, 9);
        chk("wr_wdata", tlb_wdata, {19'd1, 71'd0});
        chk("wr_rand_write", random_out, 9);
        tick();
        #1;
        chk("wr_done", write_done, 1);
        chk("wr_rand_done", random_out, 9);
        tick();
        tlbwr_req = 1'b0;
        #1;
        chk("wr_rand_idle", random_out, 9);
        chk("wr_stall_idle", stall, 0);
        tick();
        #1;
        chk("wr_rand_resume", random_out, 8);

        // Table-driven TLBWI/TLBWR packing; request held through DONE
        foreach (vecs[i]) begin
            cp0_entryhi  = vecs[i].hi;
            cp0_entrylo0 = vecs[i].lo0;
            cp0_entrylo1 = vecs[i].lo1;
            cp0_pagemask = vecs[i].pm;
            cp0_index    = vecs[i].idx;
            tlbwi_req    = vecs[i].wi;
            tlbwr_req    = vecs[i].wr;
            #1;
            chk({vecs[i].name, "_stall_T"}, stall, 1);
            chk({vecs[i].name, "_we_T"}, tlb_we, 0);
            tick();
            // Scramble CP0 after capture: the written entry must not follow it
            cp0_entryhi  = ~vecs[i].hi;
            cp0_entrylo0 = ~vecs[i].lo0;
            cp0_entrylo1 = ~vecs[i].lo1;
            cp0_pagemask = ~vecs[i].pm;
            cp0_index    = ~vecs[i].idx;
            #1;
            chk({vecs[i].name, "_stall_T1"}, stall, 1);
            chk({vecs[i].name, "_we_T1"}, tlb_we, 1);
            chk({vecs[i].name, "_widx"}, tlb_widx, vecs[i].exp_widx);
            chk({vecs[i].name, "_wdata"}, tlb_wdata, vecs[i].exp_wdata);
            tick();
            #1;
            chk({vecs[i].name, "_stall_T2"}, stall, 0);
            chk({vecs[i].name, "_we_T2"}, tlb_we, 0);
            chk({vecs[i].name, "_done_T2"}, write_done, 1);
            tick();
            tlbwi_req = 1'b0;
            tlbwr_req = 1'b0;
            #1;
            chk({vecs[i].name, "_stall_T3"}, stall, 0);
            chk({vecs[i].name, "_done_T3"}, write_done, 0);
            $display("vector %s applied", vecs[i].name);
        end

        // Back-to-back TLBWI: second accepted in the cycle after DONE
        cp0_entryhi = 32'h0000_2000;
        cp0_entrylo0 = '0;
        cp0_entrylo1 = '0;
        cp0_pagemask = '0;
        cp0_index = 32'd7;
        tlbwi_req = 1'b1;
        tick();
        #1;
        chk("b2b_widx1", tlb_widx, 7);
        tick();
        #1;
        chk("b2b_done1", write_done, 1);
        tick();
        cp0_entryhi = 32'h0000_4000;
        cp0_index = 32'd12;
        #1;
        chk("b2b_stall2", stall, 1);
        chk("b2b_done_once", write_done, 0);
        tick();
        #1;
        chk("b2b_we2", tlb_we, 1);
        chk("b2b_widx2", tlb_widx, 12);
        chk("b2b_wdata2", tlb_wdata, {19'd2, 71'd0});
        tick();
        tlbwi_req = 1'b0;
        #1;
        chk("b2b_done2", write_done, 1);
        tick();
        #1;
        chk("b2b_idle_stall", stall, 0);
        chk("b2b_idle_done", write_done, 0);

        // Reset during WRITE drops the write
        cp0_index = 32'd2;
        tlbwi_req = 1'b1;
        tick();
        #1;
        chk("rmid_we_pre", tlb_we, 1);
        rst = 1'b1;
        tlbwi_req = 1'b0;
        tick();
        #1;
        chk("rmid_we", tlb_we, 0);
        chk("rmid_stall", stall, 0);
        chk("rmid_done", write_done, 0);
        chk("rmid_rand", random_out, 15);
        rst = 1'b0;
        tick();
        #1;
        chk("rmid_done_after", write_done, 0);
        chk("rmid_we_after", tlb_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
